// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/step controller.
// Holds the FSM state encoding and default sizing used by run_ctrl and its debouncers.
package run_ctrl_pkg;

   localparam int DEBOUNCE_DEFAULT = 4;
   localparam int COUNT_W          = 8;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      STEP_IDLE  = 2'd1,
      STEP_PULSE = 2'd2,
      STEP_WAIT  = 2'd3
   } state_t;

endpackage

// File: rtl/run_ctrl_debouncer.sv
// Button conditioner: 2-flop synchronizer, stability counter and registered edge events.
// Press/release pulses come one cycle after the debounced level changes.
module run_ctrl_debouncer
   import run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_level;
   logic       r_levelDly;
   logic [7:0] r_cnt;
   logic       r_press;
   logic       r_release;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_level    <= 1'b0;
         r_levelDly <= 1'b0;
         r_cnt      <= '0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         // Any sample agreeing with the current level restarts the stability count.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
         r_levelDly <= r_level;
         r_press    <= r_level & ~r_levelDly;
         r_release  <= ~r_level & r_levelDly;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/run_ctrl.sv
// Free-run / single-step controller for the processor: mode button toggles step mode,
// step button issues one registered step pulse per debounced press.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               btn_mode,
   input  logic               btn_step,
   output logic               change,
   output logic               step,
   output logic [COUNT_W-1:0] step_count,
   output logic               busy
);

   logic w_modeLevel;
   logic w_modePress;
   logic w_modeRelease;
   logic w_stepLevel;
   logic w_stepPress;
   logic w_stepRelease;
   logic w_unused;

   state_t             r_state;
   logic               r_change;
   logic               r_step;
   logic               r_busy;
   logic [COUNT_W-1:0] r_count;

   run_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_modeDeb (
      .clock     (clock),
      .reset     (reset),
      .i_btn     (btn_mode),
      .o_level   (w_modeLevel),
      .o_press   (w_modePress),
      .o_release (w_modeRelease)
   );

   run_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepDeb (
      .clock     (clock),
      .reset     (reset),
      .i_btn     (btn_step),
      .o_level   (w_stepLevel),
      .o_press   (w_stepPress),
      .o_release (w_stepRelease)
   );

   assign w_unused = &{1'b0, w_modeLevel, w_modeRelease, w_stepRelease};

   // Mode press is checked first in every state so it always beats a coincident step press.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= RUN;
         r_change <= 1'b0;
         r_step   <= 1'b0;
         r_busy   <= 1'b0;
         r_count  <= '0;
      end else begin
         r_step <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_modePress) begin
                  r_state  <= STEP_IDLE;
                  r_change <= 1'b1;
                  r_count  <= '0;
               end
            end
            STEP_IDLE: begin
               if (w_modePress) begin
                  r_state  <= RUN;
                  r_change <= 1'b0;
               end else if (w_stepPress) begin
                  r_state <= STEP_PULSE;
                  r_step  <= 1'b1;
                  r_count <= r_count + 1'b1;
               end
            end
            STEP_PULSE: begin
               if (w_modePress) begin
                  r_state  <= RUN;
                  r_change <= 1'b0;
               end else begin
                  r_state <= STEP_WAIT;
                  r_busy  <= 1'b1;
               end
            end
            STEP_WAIT: begin
               if (w_modePress) begin
                  r_state  <= RUN;
                  r_change <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (!w_stepLevel) begin
                  r_state <= STEP_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state  <= RUN;
               r_change <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign change     = r_change;
   assign step       = r_step;
   assign busy       = r_busy;
   assign step_count = r_count;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: scenario tasks plus a pulse scoreboard
// (expected pulses queued at stimulus time, observed pulses queued by a monitor).
module tb_run_ctrl;

   localparam int DEB = 4;
   localparam int LAT = DEB + 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_step = 1'b0;
   logic       change;
   logic       step;
   logic [7:0] step_count;
   logic       busy;

   int cycle = 0;
   int nCompared = 0;
   int nMismatched = 0;

   int expCycle[$];
   int expCount[$];
   int obsCycle[$];
   int obsCount[$];

   run_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_mode   (btn_mode),
      .btn_step   (btn_step),
      .change     (change),
      .step       (step),
      .step_count (step_count),
      .busy       (busy)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cycle++;

   // Every cycle with step high is logged; a two-cycle pulse shows up as an extra entry.
   always @(negedge clock) begin
      if (step === 1'b1) begin
         obsCycle.push_back(cycle);
         obsCount.push_back(int'(step_count));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      @(posedge clock); #1;
      nCompared++;
      if ({change, step, busy, step_count} !== 11'd0) begin
         nMismatched++;
         $display("[TB] FAIL inReset: got %b, want 0", {change, step, busy, step_count});
      end
      #14;
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         nCompared++;
         if ({change, step, step_count} !== 10'd0) begin
            nMismatched++;
            $display("[TB] FAIL idleAfterReset cycle %0d: got %b, want 0", i, {change, step, step_count});
         end
      end
      nCompared++;
      if (obsCycle.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL idlePulses: got %0d pulses, want 0", obsCycle.size());
      end
   endtask

   task automatic test_mode_enter;
      tick(1);
      btn_mode = 1'b1;
      tick(LAT - 1);
      nCompared++;
      if (change !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL changeEarly: got %b, want 0", change);
      end
      tick(1);
      nCompared++;
      if (change !== 1'b1 || step_count !== 8'd0) begin
         nMismatched++;
         $display("[TB] FAIL changeOn: got change=%b count=%0d, want change=1 count=0", change, step_count);
      end
      tick(2);
      btn_mode = 1'b0;
      tick(12);
      nCompared++;
      if (change !== 1'b1 || obsCycle.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL modeRelease: got change=%b pulses=%0d, want 1/0", change, obsCycle.size());
      end
   endtask

   task automatic test_step_single;
      int c;
      tick(1);
      btn_step = 1'b1;
      c = cycle;
      expCycle.push_back(c + LAT);
      expCount.push_back(1);
      tick(LAT + 1);
      nCompared++;
      if (busy !== 1'b1 || step !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL busyAfterPulse: got busy=%b step=%b, want 1/0", busy, step);
      end
      tick(1);
      btn_step = 1'b0;
      tick(6);
      nCompared++;
      if (busy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL busyHeld: got %b, want 1", busy);
      end
      tick(1);
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL busyCleared: got %b, want 0", busy);
      end
      while (expCycle.size() > 0) begin
         int ec, en;
         ec = expCycle.pop_front();
         en = expCount.pop_front();
         nCompared++;
         if (obsCycle.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL singlePulse: got no pulse, want pulse at cycle %0d", ec);
         end else begin
            int oc, on;
            oc = obsCycle.pop_front();
            on = obsCount.pop_front();
            if (oc != ec || on != en) begin
               nMismatched++;
               $display("[TB] FAIL singlePulse: got cycle %0d count %0d, want cycle %0d count %0d", oc, on, ec, en);
            end
         end
      end
      nCompared++;
      if (obsCycle.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL singleExtra: got %0d extra pulses, want 0", obsCycle.size());
         obsCycle.delete(); obsCount.delete();
      end
   endtask

   task automatic test_glitch;
      tick(1);
      btn_step = 1'b1;
      tick(DEB - 1);
      btn_step = 1'b0;
      tick(20);
      nCompared++;
      if (obsCycle.size() != 0 || step_count !== 8'd1 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL glitch: got pulses=%0d count=%0d busy=%b, want 0/1/0", obsCycle.size(), step_count, busy);
         obsCycle.delete(); obsCount.delete();
      end
   endtask

   task automatic test_simultaneous;
      tick(1);
      btn_mode = 1'b1;
      btn_step = 1'b1;
      tick(LAT);
      nCompared++;
      if (change !== 1'b0 || step !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL modeWins: got change=%b step=%b, want 0/0", change, step);
      end
      tick(2);
      btn_mode = 1'b0;
      btn_step = 1'b0;
      tick(12);
      nCompared++;
      if (change !== 1'b0 || obsCycle.size() != 0 || step_count !== 8'd1) begin
         nMismatched++;
         $display("[TB] FAIL simulAfter: got change=%b pulses=%0d count=%0d, want 0/0/1", change, obsCycle.size(), step_count);
         obsCycle.delete(); obsCount.delete();
      end
      btn_step = 1'b1;
      tick(10);
      btn_step = 1'b0;
      tick(12);
      nCompared++;
      if (change !== 1'b0 || obsCycle.size() != 0 || step_count !== 8'd1) begin
         nMismatched++;
         $display("[TB] FAIL stepInRun: got change=%b pulses=%0d count=%0d, want 0/0/1", change, obsCycle.size(), step_count);
         obsCycle.delete(); obsCount.delete();
      end
   endtask

   task automatic test_wrap;
      tick(1);
      btn_mode = 1'b1;
      tick(LAT);
      nCompared++;
      if (change !== 1'b1 || step_count !== 8'd0) begin
         nMismatched++;
         $display("[TB] FAIL reenter: got change=%b count=%0d, want 1/0", change, step_count);
      end
      tick(2);
      btn_mode = 1'b0;
      tick(12);
      for (int k = 0; k < 256; k++) begin
         tick(1);
         btn_step = 1'b1;
         expCycle.push_back(cycle + LAT);
         expCount.push_back((k + 1) % 256);
         tick(LAT + 1);
         btn_step = 1'b0;
         tick(9);
      end
      while (expCycle.size() > 0) begin
         int ec, en;
         ec = expCycle.pop_front();
         en = expCount.pop_front();
         nCompared++;
         if (obsCycle.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL wrapPulse: got no pulse, want pulse at cycle %0d count %0d", ec, en);
         end else begin
            int oc, on;
            oc = obsCycle.pop_front();
            on = obsCount.pop_front();
            if (oc != ec || on != en) begin
               nMismatched++;
               $display("[TB] FAIL wrapPulse: got cycle %0d count %0d, want cycle %0d count %0d", oc, on, ec, en);
            end
         end
      end
      nCompared++;
      if (obsCycle.size() != 0 || step_count !== 8'd0) begin
         nMismatched++;
         $display("[TB] FAIL wrapEnd: got extra=%0d count=%0d, want 0/0", obsCycle.size(), step_count);
         obsCycle.delete(); obsCount.delete();
      end
   endtask

   task automatic test_reset_mid_pulse;
      tick(1);
      btn_step = 1'b1;
      tick(LAT);
      nCompared++;
      if (step !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL pulseBeforeReset: got %b, want 1", step);
      end
      reset = 1'b0;
      btn_mode = 1'b1;
      #1;
      nCompared++;
      if ({change, step, busy, step_count} !== 11'd0) begin
         nMismatched++;
         $display("[TB] FAIL resetMidPulse: got %b, want 0", {change, step, busy, step_count});
      end
      tick(2);
      reset = 1'b1;
      tick(LAT - 1);
      nCompared++;
      if (change !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL heldEarly: got %b, want 0", change);
      end
      tick(1);
      nCompared++;
      if (change !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL heldAsPress: got %b, want 1", change);
      end
      tick(10);
      nCompared++;
      if (obsCycle.size() != 0 || step_count !== 8'd0) begin
         nMismatched++;
         $display("[TB] FAIL afterReset: got pulses=%0d count=%0d, want 0/0", obsCycle.size(), step_count);
      end
      btn_mode = 1'b0;
      btn_step = 1'b0;
      tick(12);
   endtask

   initial begin
      test_reset();
      test_mode_enter();
      test_step_single();
      test_glitch();
      test_simultaneous();
      test_wrap();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
